// File: rtl/rename_ckpt.sv
// rename_ckpt: register rename stage with a circular physical free list, ROB tagging
// and NUM_CKPT branch checkpoints for single-cycle mispredict recovery.
// Optional feature macro: RENAME_PERF_EN adds three 32-bit saturating perf counters.
module rename_ckpt #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 128,
    parameter int ROB_DEPTH = 16,
    parameter int NUM_CKPT  = 4,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int TW = $clog2(ROB_DEPTH),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    output logic          ready_in,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [AW-1:0] in_rd,
    input  logic          in_writes_rd,
    input  logic          in_is_branch,
    output logic          valid_out,
    input  logic          ready_out,
    output logic [PW-1:0] out_ps1,
    output logic [PW-1:0] out_ps2,
    output logic [PW-1:0] out_pd_old,
    output logic [PW-1:0] out_pd_new,
    output logic [TW-1:0] out_rob_tag,
    output logic [CW-1:0] out_ckpt_id,
    output logic          out_is_branch,
    input  logic          commit_valid,
    input  logic [PW-1:0] commit_pd_old,
    input  logic          resolve_valid,
    input  logic [CW-1:0] resolve_ckpt,
    input  logic          resolve_mispredict
`ifdef RENAME_PERF_EN
    ,
    output logic [31:0]   perf_stall_free,
    output logic [31:0]   perf_stall_ckpt,
    output logic [31:0]   perf_flush
`endif
);
    localparam int FL  = PHYS_REGS - ARCH_REGS;
    localparam int FIW = $clog2(FL);
    localparam int FCW = $clog2(FL + 1);
    localparam logic [CW:0] CK_FULL = (CW + 1)'(NUM_CKPT);

    // Free-list pointer: slot index plus a wrap bit that toggles each lap,
    // so full and empty are distinguishable with a non-power-of-two list size.
    typedef struct packed {
        logic           wrap;
        logic [FIW-1:0] idx;
    } fptr_t;

    function automatic fptr_t fptr_inc(input fptr_t p);
        fptr_t r;
        if (p.idx == FIW'(FL - 1)) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + FIW'(1);
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    // Register 0 has no map entry; it always reads as physical 0.
    logic [PW-1:0] map_q [1:ARCH_REGS-1];
    logic [PW-1:0] map_d [1:ARCH_REGS-1];
    logic [PW-1:0] fl_q [FL];
    logic [PW-1:0] fl_d [FL];
    fptr_t         fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;

    logic [PW-1:0] ck_map_q [NUM_CKPT][1:ARCH_REGS-1];
    logic [PW-1:0] ck_map_d [NUM_CKPT][1:ARCH_REGS-1];
    fptr_t         ck_head_q [NUM_CKPT];
    fptr_t         ck_head_d [NUM_CKPT];
    logic [TW-1:0] ck_rob_q [NUM_CKPT];
    logic [TW-1:0] ck_rob_d [NUM_CKPT];
    logic [CW-1:0] ck_hd_q, ck_hd_d, ck_tl_q, ck_tl_d;
    logic [CW:0]   ck_cnt_q, ck_cnt_d;

    logic [TW-1:0] rob_q, rob_d;

    logic          vo_q, vo_d;
    logic [PW-1:0] ps1_q, ps1_d, ps2_q, ps2_d, pdo_q, pdo_d, pdn_q, pdn_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [CW-1:0] ckid_q, ckid_d;
    logic          isbr_q, isbr_d;

    logic [FCW-1:0] free_cnt;
    logic           alloc, mispredict, fire;
    logic [PW-1:0]  pd_new;
    logic [TW-1:0]  rob_next;

    // Occupancy of the free list from the wrap-extended pointers.
    always_comb begin
        if (fl_tail_q.wrap == fl_head_q.wrap)
            free_cnt = FCW'(fl_tail_q.idx) - FCW'(fl_head_q.idx);
        else
            free_cnt = FCW'(FL) - FCW'(fl_head_q.idx) + FCW'(fl_tail_q.idx);
    end

    // Accept handshake; a mispredict cycle blocks intake so recovery wins.
    always_comb begin
        alloc      = in_writes_rd && (in_rd != '0);
        mispredict = resolve_valid && resolve_mispredict;
        ready_in   = !reset && (!vo_q || ready_out) && (!alloc || free_cnt != '0) &&
                     (!in_is_branch || ck_cnt_q != CK_FULL) && !mispredict;
        fire       = valid_in && ready_in;
        rob_next   = (rob_q == TW'(ROB_DEPTH - 1)) ? '0 : rob_q + TW'(1);
        pd_new     = alloc ? fl_q[fl_head_q.idx] : '0;
    end

    // Next-state for map, free list, checkpoints, rob counter and output register.
    always_comb begin
        map_d     = map_q;
        fl_d      = fl_q;
        fl_head_d = fl_head_q;
        fl_tail_d = fl_tail_q;
        ck_map_d  = ck_map_q;
        ck_head_d = ck_head_q;
        ck_rob_d  = ck_rob_q;
        ck_hd_d   = ck_hd_q;
        ck_tl_d   = ck_tl_q;
        ck_cnt_d  = ck_cnt_q;
        rob_d     = rob_q;
        vo_d      = vo_q;
        ps1_d     = ps1_q;
        ps2_d     = ps2_q;
        pdo_d     = pdo_q;
        pdn_d     = pdn_q;
        tag_d     = tag_q;
        ckid_d    = ckid_q;
        isbr_d    = isbr_q;

        if (commit_valid && commit_pd_old != '0) begin
            fl_d[fl_tail_q.idx] = commit_pd_old;
            fl_tail_d           = fptr_inc(fl_tail_q);
        end

        if (fire) begin
            vo_d   = 1'b1;
            ps1_d  = (in_rs1 == '0) ? '0 : map_q[in_rs1];
            ps2_d  = (in_rs2 == '0) ? '0 : map_q[in_rs2];
            pdo_d  = (in_rd == '0) ? '0 : map_q[in_rd];
            pdn_d  = pd_new;
            tag_d  = rob_q;
            isbr_d = in_is_branch;
            ckid_d = in_is_branch ? ck_tl_q : '0;
            rob_d  = rob_next;
            if (alloc) begin
                map_d[in_rd] = pd_new;
                fl_head_d    = fptr_inc(fl_head_q);
            end
            // Snapshot reflects this branch's own effects, so recovery resumes right after it.
            if (in_is_branch) begin
                for (int r = 1; r < ARCH_REGS; r++) ck_map_d[ck_tl_q][r] = map_d[r];
                ck_head_d[ck_tl_q] = fl_head_d;
                ck_rob_d[ck_tl_q]  = rob_next;
                ck_tl_d            = ck_tl_q + CW'(1);
                ck_cnt_d           = ck_cnt_q + (CW + 1)'(1);
            end
        end else if (ready_out) begin
            vo_d = 1'b0;
        end

        if (resolve_valid && !resolve_mispredict && ck_cnt_q != '0) begin
            ck_hd_d  = ck_hd_q + CW'(1);
            ck_cnt_d = ck_cnt_d - (CW + 1)'(1);
        end

        if (mispredict) begin
            for (int r = 1; r < ARCH_REGS; r++) map_d[r] = ck_map_q[resolve_ckpt][r];
            fl_head_d = ck_head_q[resolve_ckpt];
            rob_d     = ck_rob_q[resolve_ckpt];
            ck_tl_d   = resolve_ckpt;
            ck_cnt_d  = {1'b0, CW'(resolve_ckpt - ck_hd_q)};
            vo_d      = 1'b0;
        end
    end

    // State registers; reset rebuilds the identity map and a full free list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < ARCH_REGS; r++) map_q[r] <= PW'(r);
            for (int i = 0; i < FL; i++) fl_q[i] <= PW'(ARCH_REGS + i);
            for (int c = 0; c < NUM_CKPT; c++) begin
                for (int r = 1; r < ARCH_REGS; r++) ck_map_q[c][r] <= '0;
                ck_head_q[c] <= '0;
                ck_rob_q[c]  <= '0;
            end
            fl_head_q <= '0;
            fl_tail_q <= '{wrap: 1'b1, idx: '0};
            ck_hd_q   <= '0;
            ck_tl_q   <= '0;
            ck_cnt_q  <= '0;
            rob_q     <= '0;
            vo_q      <= 1'b0;
            ps1_q     <= '0;
            ps2_q     <= '0;
            pdo_q     <= '0;
            pdn_q     <= '0;
            tag_q     <= '0;
            ckid_q    <= '0;
            isbr_q    <= 1'b0;
        end else begin
            map_q     <= map_d;
            fl_q      <= fl_d;
            ck_map_q  <= ck_map_d;
            ck_head_q <= ck_head_d;
            ck_rob_q  <= ck_rob_d;
            fl_head_q <= fl_head_d;
            fl_tail_q <= fl_tail_d;
            ck_hd_q   <= ck_hd_d;
            ck_tl_q   <= ck_tl_d;
            ck_cnt_q  <= ck_cnt_d;
            rob_q     <= rob_d;
            vo_q      <= vo_d;
            ps1_q     <= ps1_d;
            ps2_q     <= ps2_d;
            pdo_q     <= pdo_d;
            pdn_q     <= pdn_d;
            tag_q     <= tag_d;
            ckid_q    <= ckid_d;
            isbr_q    <= isbr_d;
        end
    end

    assign valid_out     = vo_q;
    assign out_ps1       = ps1_q;
    assign out_ps2       = ps2_q;
    assign out_pd_old    = pdo_q;
    assign out_pd_new    = pdn_q;
    assign out_rob_tag   = tag_q;
    assign out_ckpt_id   = ckid_q;
    assign out_is_branch = isbr_q;

`ifdef RENAME_PERF_EN
    logic [31:0] pf_free_q, pf_free_d, pf_ckpt_q, pf_ckpt_d, pf_flush_q, pf_flush_d;

    // Saturating event counters for resource stalls and flushes.
    always_comb begin
        pf_free_d  = pf_free_q;
        pf_ckpt_d  = pf_ckpt_q;
        pf_flush_d = pf_flush_q;
        if (valid_in && alloc && free_cnt == '0 && pf_free_q != '1)
            pf_free_d = pf_free_q + 32'd1;
        if (valid_in && in_is_branch && ck_cnt_q == CK_FULL && pf_ckpt_q != '1)
            pf_ckpt_d = pf_ckpt_q + 32'd1;
        if (mispredict && pf_flush_q != '1)
            pf_flush_d = pf_flush_q + 32'd1;
    end

    // Perf counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_free_q  <= '0;
            pf_ckpt_q  <= '0;
            pf_flush_q <= '0;
        end else begin
            pf_free_q  <= pf_free_d;
            pf_ckpt_q  <= pf_ckpt_d;
            pf_flush_q <= pf_flush_d;
        end
    end

    assign perf_stall_free = pf_free_q;
    assign perf_stall_ckpt = pf_ckpt_q;
    assign perf_flush      = pf_flush_q;
`endif

endmodule

// File: tb/tb_rename_ckpt.sv
// Scoreboard bench for rename_ckpt: stimulus pushes hand-computed expected outputs,
// a negedge monitor pops and compares on every output handshake.
module tb_rename_ckpt;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0, ready_in;
    logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic       in_writes_rd = 1'b0, in_is_branch = 1'b0;
    logic       valid_out, ready_out = 1'b1;
    logic [6:0] out_ps1, out_ps2, out_pd_old, out_pd_new;
    logic [3:0] out_rob_tag;
    logic [1:0] out_ckpt_id;
    logic       out_is_branch;
    logic       commit_valid = 1'b0;
    logic [6:0] commit_pd_old = '0;
    logic       resolve_valid = 1'b0, resolve_mispredict = 1'b0;
    logic [1:0] resolve_ckpt = '0;
`ifdef RENAME_PERF_EN
    logic [31:0] perf_stall_free, perf_stall_ckpt, perf_flush;
`endif

    rename_ckpt dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_writes_rd(in_writes_rd), .in_is_branch(in_is_branch),
        .valid_out(valid_out), .ready_out(ready_out),
        .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd_old(out_pd_old), .out_pd_new(out_pd_new),
        .out_rob_tag(out_rob_tag), .out_ckpt_id(out_ckpt_id), .out_is_branch(out_is_branch),
        .commit_valid(commit_valid), .commit_pd_old(commit_pd_old),
        .resolve_valid(resolve_valid), .resolve_ckpt(resolve_ckpt),
        .resolve_mispredict(resolve_mispredict)
`ifdef RENAME_PERF_EN
        ,
        .perf_stall_free(perf_stall_free), .perf_stall_ckpt(perf_stall_ckpt), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] ps1;
        logic [6:0] ps2;
        logic [6:0] pdo;
        logic [6:0] pdn;
        logic [3:0] tag;
        logic [1:0] ck;
        logic       br;
    } exp_t;

    exp_t q[$];
    int   vec  = 0;
    int   errs = 0;

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one comparison per accepted output beat.
    always @(negedge clk) begin
        exp_t a, e;
        if (!reset && valid_out && ready_out) begin
            a = {out_ps1, out_ps2, out_pd_old, out_pd_new, out_rob_tag, out_ckpt_id, out_is_branch};
            vec++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL out_unexpected: got pd_new=%0d tag=%0d with no expected entry", out_pd_new, out_rob_tag);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errs++;
                    $display("FAIL out_vec: got ps1=%0d ps2=%0d pdo=%0d pdn=%0d tag=%0d ck=%0d br=%0d expected ps1=%0d ps2=%0d pdo=%0d pdn=%0d tag=%0d ck=%0d br=%0d",
                             a.ps1, a.ps2, a.pdo, a.pdn, a.tag, a.ck, a.br,
                             e.ps1, e.ps2, e.pdo, e.pdn, e.tag, e.ck, e.br);
                end
            end
        end
    end

    // Drive one instruction, wait (bounded) for acceptance, and record its expected output.
    task automatic issue(input int rs1, rs2, rd, wr, br,
                         input int e_ps1, e_ps2, e_pdo, e_pdn, e_tag, e_ck);
        int n = 0;
        in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd);
        in_writes_rd = wr[0]; in_is_branch = br[0]; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) begin
            vec++;
            errs++;
            $display("FAIL issue_timeout: ready_in=0 required 1 (rd=%0d br=%0d)", rd, br);
        end else begin
            q.push_back({7'(e_ps1), 7'(e_ps2), 7'(e_pdo), 7'(e_pdn), 4'(e_tag), 2'(e_ck), br[0]});
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic mispredict(input int k);
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_ckpt = 2'(k);
        @(negedge clk);
        chk("mp_ready_in", ready_in, 0);
        @(posedge clk); #1;
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        chk("mp_valid_out_cleared", valid_out, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("drain_pending", q.size(), 0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        valid_in = 1'b1; in_writes_rd = 1'b1; in_rd = 5'd5; in_is_branch = 1'b0;
        #1;
        q.delete();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_pd_new", out_pd_new, 0);
        chk("rst_ps1", out_ps1, 0);
        chk("rst_rob_tag", out_rob_tag, 0);
        chk("rst_ready_in", ready_in, 0);
`ifdef RENAME_PERF_EN
        chk("rst_perf_free", perf_stall_free, 0);
        chk("rst_perf_ckpt", perf_stall_ckpt, 0);
        chk("rst_perf_flush", perf_flush, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0; in_writes_rd = 1'b0; in_rd = '0;
        @(posedge clk); #1;
        chk("post_rst_ready_in", ready_in, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic rename and output hold under backpressure.
        do_reset();
        ready_out = 1'b0;
        issue(1, 2, 5, 1, 0,  1, 2, 5, 32, 0, 0);
        in_rs1 = 5'd5; in_rs2 = '0; in_rd = 5'd5; in_writes_rd = 1'b1; in_is_branch = 1'b0;
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_ready_in", ready_in, 0);
            chk("hold_valid_out", valid_out, 1);
            chk("hold_pd_new", out_pd_new, 32);
            chk("hold_rob_tag", out_rob_tag, 0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        issue(5, 0, 5, 1, 0,  32, 0, 32, 33, 1, 0);
        chk("release_valid_out", valid_out, 1);
        chk("release_pd_new", out_pd_new, 33);
        chk("release_ps1", out_ps1, 32);

        // Free-list exhaustion, ignored zero commit, reuse of a committed register, rob wrap.
        do_reset();
        for (int i = 0; i < 96; i++)
            issue(0, 0, (i % 31) + 1, 1, 0,  0, 0, i + 1, 32 + i, i % 16, 0);
        in_rs1 = '0; in_rs2 = '0; in_rd = 5'd4; in_writes_rd = 1'b1; in_is_branch = 1'b0;
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("free_empty_ready_in", ready_in, 0);
        end
        commit_valid = 1'b1; commit_pd_old = 7'd0;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        @(negedge clk);
        chk("commit_zero_ignored", ready_in, 0);
        commit_valid = 1'b1; commit_pd_old = 7'd7;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        issue(0, 0, 4, 1, 0,  0, 0, 97, 7, 0, 0);
`ifdef RENAME_PERF_EN
        chk("perf_stall_free", perf_stall_free, 4);
`endif
        drain();

        // Checkpoint, mispredict recovery, checkpoint full, correct resolve, younger-slot recovery.
        do_reset();
        issue(1, 2, 0, 0, 1,  1, 2, 0, 0, 0, 0);
        issue(3, 0, 3, 1, 0,  3, 0, 3, 32, 1, 0);
        issue(3, 0, 4, 1, 0,  32, 0, 4, 33, 2, 0);
        issue(4, 0, 3, 1, 0,  33, 0, 32, 34, 3, 0);
        mispredict(0);
        issue(3, 4, 3, 1, 0,  3, 4, 3, 32, 1, 0);
        issue(3, 0, 0, 0, 1,  32, 0, 0, 0, 2, 0);
        issue(3, 0, 0, 0, 1,  32, 0, 0, 0, 3, 1);
        issue(3, 0, 0, 0, 1,  32, 0, 0, 0, 4, 2);
        issue(3, 0, 0, 0, 1,  32, 0, 0, 0, 5, 3);
        in_rs1 = 5'd3; in_rs2 = '0; in_rd = '0; in_writes_rd = 1'b0; in_is_branch = 1'b1;
        valid_in = 1'b1;
        @(negedge clk);
        chk("ckpt_full_ready_in", ready_in, 0);
        @(negedge clk);
        chk("ckpt_full_ready_in", ready_in, 0);
        resolve_valid = 1'b1; resolve_mispredict = 1'b0; resolve_ckpt = 2'd0;
        @(posedge clk); #1;
        resolve_valid = 1'b0;
        issue(3, 0, 0, 0, 1,  32, 0, 0, 0, 6, 0);
        mispredict(2);
        issue(3, 0, 0, 0, 1,  32, 0, 0, 0, 5, 2);
        issue(6, 0, 6, 1, 0,  6, 0, 6, 33, 6, 0);
`ifdef RENAME_PERF_EN
        chk("perf_stall_ckpt", perf_stall_ckpt, 2);
        chk("perf_flush", perf_flush, 2);
        chk("perf_stall_free_zero", perf_stall_free, 0);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
